adc_ch_avg: RTL

ADC_CH_AVG -- requirements
Module: adc_ch_avg

---
 rtl/adc_ch_avg.sv | 135 +++++++++++++
 1 files changed

// File: rtl/adc_ch_avg.sv
// Per-channel block averager: sums 2^LOG2_N frames of NCH interleaved ADC samples and streams the averages.
// Optional ADC_CH_AVG_ROUND_EN selects round-half-up instead of floor on the final shift.
module adc_ch_avg #(
  parameter int DATA_W = 16,
  parameter int NCH    = 6,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic [2:0]        din_ch,
  input  logic              sync_clr,
  output logic [DATA_W-1:0] avg_o,
  output logic [2:0]        avg_ch,
  output logic              avg_vld,
  input  logic              avg_rdy,
  output logic              ovf,
  output logic              ch_err
);

  localparam int                ACC_W      = DATA_W + LOG2_N;
  localparam logic [2:0]        LAST_CH    = 3'(NCH - 1);
  localparam logic [LOG2_N-1:0] LAST_FRAME = {LOG2_N{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, DUMP = 1'b1} state_t;

  logic signed [ACC_W-1:0]  acc_r     [NCH];
  logic signed [ACC_W-1:0]  acc_nxt_s [NCH];
  logic        [DATA_W-1:0] res_r     [NCH];
  logic        [LOG2_N-1:0] frame_cnt_r;
  logic        [2:0]        idx_r;
  logic        [2:0]        idx_inc_s;
  state_t                   state_r, state_nxt_s;
  logic signed [ACC_W-1:0]  din_ext_s;
  logic                     ch_bad_s, samp_ok_s, frame_end_s, block_done_s;
  logic                     xfer_s, last_xfer_s;

  // Sum width has LOG2_N bits of headroom, so the optional rounding bias cannot overflow.
  function automatic logic [DATA_W-1:0] avg_of(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] t;
`ifdef ADC_CH_AVG_ROUND_EN
    t = sum + (ACC_W'(1) << (LOG2_N - 1));
`else
    t = sum;
`endif
    t = t >>> LOG2_N;
    return t[DATA_W-1:0];
  endfunction

  assign din_ext_s    = {{LOG2_N{din[DATA_W-1]}}, din};
  assign ch_bad_s     = din_vld && (din_ch > LAST_CH);
  assign samp_ok_s    = din_vld && !ch_bad_s && !sync_clr;
  assign frame_end_s  = samp_ok_s && (din_ch == LAST_CH);
  assign block_done_s = frame_end_s && (frame_cnt_r == LAST_FRAME);
  assign xfer_s       = avg_vld && avg_rdy;
  assign last_xfer_s  = xfer_s && (idx_r == LAST_CH);
  assign idx_inc_s    = idx_r + 3'd1;

  // Next accumulator values, including the sample arriving this cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      acc_nxt_s[i] = acc_r[i];
      if (samp_ok_s && (din_ch == 3'(i))) begin
        acc_nxt_s[i] = acc_r[i] + din_ext_s;
      end else begin
        acc_nxt_s[i] = acc_r[i];
      end
    end
  end

  // Dump FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (block_done_s) state_nxt_s = DUMP;
        else              state_nxt_s = IDLE;
      end
      DUMP: begin
        if (last_xfer_s) state_nxt_s = IDLE;
        else             state_nxt_s = DUMP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_l) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Accumulators and frame counter; a finished block clears them even when its results are dropped.
  always_ff @(posedge clk) begin
    if (!rst_l || sync_clr || block_done_s) begin
      for (int i = 0; i < NCH; i++) acc_r[i] <= {ACC_W{1'b0}};
      frame_cnt_r <= {LOG2_N{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) acc_r[i] <= acc_nxt_s[i];
      if (frame_end_s) frame_cnt_r <= frame_cnt_r + {{(LOG2_N-1){1'b0}}, 1'b1};
      else             frame_cnt_r <= frame_cnt_r;
    end
  end

  // Result latch, output word sequencing and status flags.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < NCH; i++) res_r[i] <= {DATA_W{1'b0}};
      avg_o   <= {DATA_W{1'b0}};
      avg_ch  <= 3'd0;
      avg_vld <= 1'b0;
      idx_r   <= 3'd0;
      ovf     <= 1'b0;
      ch_err  <= 1'b0;
    end else begin
      ch_err <= ch_bad_s;
      if (block_done_s && (state_r == DUMP)) ovf <= 1'b1;
      if (block_done_s && (state_r == IDLE)) begin
        for (int i = 0; i < NCH; i++) res_r[i] <= avg_of(acc_nxt_s[i]);
        avg_o   <= avg_of(acc_nxt_s[0]);
        avg_ch  <= 3'd0;
        idx_r   <= 3'd0;
        avg_vld <= 1'b1;
      end else if (last_xfer_s) begin
        avg_vld <= 1'b0;
      end else if (xfer_s) begin
        idx_r  <= idx_inc_s;
        avg_o  <= res_r[idx_inc_s];
        avg_ch <= idx_inc_s;
      end
    end
  end

endmodule
